// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative radix-2 restoring divider.
//   div_state_e : FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   div_cnt_w() : width of the iteration counter, $clog2(width)+1
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic int div_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits.
// Ports:
//   rem      in   WIDTH  partial remainder before this step (always < dsr)
//   dvd_bit  in   1      next dividend bit, MSB first
//   dsr      in   WIDTH  divisor magnitude
//   rem_next out  WIDTH  partial remainder after this step
//   q_bit    out  1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder needs one extra bit so the compare cannot wrap.
    logic [WIDTH:0] trial;

    assign trial = {rem, dvd_bit};
    assign q_bit = (trial >= {1'b0, dsr});
    // When the subtraction is taken the result is < dsr, so the low WIDTH
    // bits of the difference are exact and the carry-out can be dropped.
    assign rem_next = q_bit ? (trial[WIDTH-1:0] - dsr) : trial[WIDTH-1:0];

endmodule

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per
// cycle. Operates on magnitudes and applies sign fixup in the DONE state:
// quotient truncates toward zero, remainder takes the dividend's sign.
// Divide by zero returns s = all-ones, r = raw dividend.
// Optional build macro:
//   DIV_ZERO_FAST_EN  a zero divisor skips the iterations (IDLE -> DONE)
// Ports:
//   div_clk     in   1      clock
//   resetn      in   1      synchronous active-low reset
//   div_valid   in   1      request valid
//   div_ready   out  1      high only in IDLE; accept = div_valid & div_ready
//   div_signed  in   1      1: two's-complement operands, 0: unsigned
//   x           in   WIDTH  dividend
//   y           in   WIDTH  divisor
//   cancel      in   1      abort the in-flight op; ignored in IDLE
//   s           out  WIDTH  quotient, held until overwritten by a later result
//   r           out  WIDTH  remainder, held until overwritten by a later result
//   complete    out  1      one-cycle pulse, s and r valid
// -----------------------------------------------------------------------------
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             complete
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] dvd_q;      // dividend magnitude, shifts left; quotient fills from LSB
    logic [WIDTH-1:0] dsr_q;      // divisor magnitude
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] x_q;        // raw dividend for the divide-by-zero result
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic             dsr_zero_q;

    logic             accept;
    logic             last_iter;
    logic             y_zero;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    assign div_ready = (state_q == DIV_IDLE);
    assign accept    = div_valid & div_ready;
    assign last_iter = (count_q == CNT_W'(WIDTH - 1));
    assign y_zero    = (y == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[WIDTH-1]),
        .dsr      (dsr_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge div_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) state_q <= DIV_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first, so no path leaves state_d unassigned and
        // no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = y_zero ? DIV_DONE : DIV_BUSY;
`else
                    state_d = DIV_BUSY;
`endif
                end
            end
            DIV_BUSY: begin
                // cancel takes priority over the final iteration
                if (cancel)         state_d = DIV_IDLE;
                else if (last_iter) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // --------------------------------------------------- operand datapath
    // NOTE: these registers are deliberately not reset; each is loaded on
    // accept before it is ever read, and results leave only through s/r.
    always_ff @(posedge div_clk) begin
        if (accept) begin
            dvd_q      <= (div_signed && x[WIDTH-1]) ? -x : x;
            dsr_q      <= (div_signed && y[WIDTH-1]) ? -y : y;
            rem_q      <= '0;
            x_q        <= x;
            quo_neg_q  <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            rem_neg_q  <= div_signed & x[WIDTH-1];
            dsr_zero_q <= y_zero;
        end else if (state_q == DIV_BUSY && !cancel) begin
            rem_q <= rem_next;
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
        end
    end

    // ------------------------------------------- counter and result regs
    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            count_q  <= '0;
            s        <= '0;
            r        <= '0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            if (accept) begin
                count_q <= '0;
            end else if (state_q == DIV_BUSY && !cancel) begin
                count_q <= count_q + CNT_W'(1);
            end else if (state_q == DIV_DONE && !cancel) begin
                if (dsr_zero_q) begin
                    s <= '1;
                    r <= x_q;
                end else begin
                    s <= quo_neg_q ? -dvd_q : dvd_q;
                    r <= rem_neg_q ? -rem_q : rem_q;
                end
                complete <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div
// Directed self-checking bench for div (WIDTH=32). Inputs change 1 time unit
// after the rising edge, outputs are sampled at the same point. Latency is
// counted in clock edges after the accepting edge until complete is seen.
// Honours DIV_ZERO_FAST_EN for the divide-by-zero latency.
// -----------------------------------------------------------------------------
module tb_div;

    localparam int W       = 32;
    localparam int LAT     = W + 1;   // edges after accept edge until complete visible
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_Z   = 1;
`else
    localparam int LAT_Z   = W + 1;
`endif

    logic         div_clk = 1'b0;
    logic         resetn;
    logic         div_valid;
    logic         div_ready;
    logic         div_signed;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cancel;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         complete;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_s;
    logic [W-1:0] last_r;

    div #(.WIDTH(W)) dut (
        .div_clk    (div_clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .cancel     (cancel),
        .s          (s),
        .r          (r),
        .complete   (complete)
    );

    always #5 div_clk = ~div_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge div_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request and let one edge accept it.
    task automatic start_op(input string tag, input logic sgn, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit hold);
        div_signed = sgn;
        x          = a;
        y          = b;
        div_valid  = 1'b1;
        check({tag, "_ready_idle"}, {31'd0, div_ready}, 32'd1);
        tick();
        if (!hold) div_valid = 1'b0;
        check({tag, "_ready_busy"}, {31'd0, div_ready}, 32'd0);
    endtask

    // Wait (bounded) for complete, check latency and result, then check the
    // pulse drops while the result is held.
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [W-1:0] es, input logic [W-1:0] er);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!complete && n < 100);
        check({tag, "_latency"}, W'(n), W'(exp_lat));
        check({tag, "_s"}, s, es);
        check({tag, "_r"}, r, er);
        tick();
        check({tag, "_pulse"}, {31'd0, complete}, 32'd0);
        check({tag, "_s_held"}, s, es);
        last_s = es;
        last_r = er;
    endtask

    initial begin
        resetn     = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        x          = '0;
        y          = '0;
        cancel     = 1'b0;
        tick();
        tick();
        check("rst_ready",    {31'd0, div_ready}, 32'd1);
        check("rst_complete", {31'd0, complete},  32'd0);
        check("rst_s", s, 32'd0);
        check("rst_r", r, 32'd0);
        resetn = 1'b1;
        tick();

        // 1. unsigned 100/7
        start_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        wait_done("u100_7", LAT, 32'd14, 32'd2);

        // 2. signed sign combinations
        start_op("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("sm7_2", LAT, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        start_op("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_done("s7_m2", LAT, 32'hFFFF_FFFD, 32'd1);
        start_op("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
        wait_done("sm100_7", LAT, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

        // 3. signed overflow, unsigned max
        start_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("s_ovf", LAT, 32'h8000_0000, 32'd0);
        start_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done("u_max", LAT, 32'hFFFF_FFFF, 32'd0);

        // 4. divide by zero, unsigned and signed
        start_op("u_dz", 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        wait_done("u_dz", LAT_Z, 32'hFFFF_FFFF, 32'h0000_1234);
        start_op("s_dz", 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
        wait_done("s_dz", LAT_Z, 32'hFFFF_FFFF, 32'hFFFF_FF00);

        // 5. cancel at iteration 10, then 9/3
        start_op("cxl_busy", 1'b0, 32'd1000, 32'd3, 1'b0);
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cxl_busy_ready",    {31'd0, div_ready}, 32'd1);
        check("cxl_busy_complete", {31'd0, complete},  32'd0);
        check("cxl_busy_s", s, last_s);
        check("cxl_busy_r", r, last_r);
        start_op("u9_3", 1'b0, 32'd9, 32'd3, 1'b0);
        wait_done("u9_3", LAT, 32'd3, 32'd0);

        // cancel while in DONE: no pulse, result registers untouched
        start_op("cxl_done", 1'b0, 32'd50, 32'd5, 1'b0);
        repeat (W) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cxl_done_ready",    {31'd0, div_ready}, 32'd1);
        check("cxl_done_complete", {31'd0, complete},  32'd0);
        check("cxl_done_s", s, last_s);
        check("cxl_done_r", r, last_r);

        // 6. div_valid held through BUSY with changing x is not re-sampled
        start_op("hold", 1'b0, 32'd100, 32'd7, 1'b1);
        x = 32'h0000_DEAD;
        wait_done("hold", LAT, 32'd14, 32'd2);   // held request accepted on pulse edge
        div_valid = 1'b0;
        repeat (5) tick();
        resetn = 1'b0;
        tick();
        check("rst_mid_ready",    {31'd0, div_ready}, 32'd1);
        check("rst_mid_complete", {31'd0, complete},  32'd0);
        check("rst_mid_s", s, 32'd0);
        check("rst_mid_r", r, 32'd0);
        resetn = 1'b1;
        tick();

        start_op("post_rst", 1'b0, 32'd1000, 32'd3, 1'b0);
        wait_done("post_rst", LAT, 32'd333, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
